// File: rtl/bundle_decoder_pkg.sv
// Shared types and helpers for the restoring-bundle decoder and related organ blocks.
// Pure package: no logic or timing of its own.
package bundle_decoder_pkg;

  typedef enum logic [1:0] {DEC_ZERO, DEC_ONE, DEC_AMBIG} dec_class_e;

  // Widest statistics counter that sat_inc can handle.
  localparam int SAT_MAX_W = 64;

  function automatic int popcount_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (width >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}}
                                   : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/bundle_popcount.sv
// Combinational popcount of an N-wire bundle; zero latency, no handshake.
// Output is wide enough to hold N itself.
module bundle_popcount
  import bundle_decoder_pkg::*;
#(
  parameter int N = 10,
  localparam int PW = popcount_width(N)
) (
  input  logic [N-1:0]  bits,
  output logic [PW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/bundle_decoder.sv
// Thresholded-popcount decoder for a restoring wire bundle with saturating error statistics.
// Two-stage pipeline, 2-cycle latency, accepts one bundle every cycle, no backpressure.
module bundle_decoder
  import bundle_decoder_pkg::*;
#(
  parameter int N         = 10,
  parameter int THRESH_HI = 7,
  parameter int THRESH_LO = 3,
  parameter int CNT_W     = 32,
  localparam int PW = popcount_width(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     bundle_i,
  input  logic             bundle_valid_i,
  input  logic             expected_i,
  input  logic             clear_i,
  output logic             bit_o,
  output logic             ambiguous_o,
  output logic [PW-1:0]    popcount_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] samples_o,
  output logic [CNT_W-1:0] errors_o,
  output logic [CNT_W-1:0] ambig_cnt_o
);

  if (THRESH_LO < 0 || THRESH_LO >= THRESH_HI || THRESH_HI > N) begin : g_bad_thresh
    $error("bundle_decoder: thresholds must satisfy 0 <= THRESH_LO < THRESH_HI <= N");
  end
  if (CNT_W < 1 || CNT_W > SAT_MAX_W) begin : g_bad_cnt_w
    $error("bundle_decoder: CNT_W out of supported range");
  end

  localparam logic [PW-1:0] HI_P = PW'(THRESH_HI);
  localparam logic [PW-1:0] LO_P = PW'(THRESH_LO);
  localparam logic [PW:0]   N_P  = (PW + 1)'(N);

  logic [PW-1:0] pop_now;
  logic [PW-1:0] s1_pop;
  logic          s1_exp;
  logic          s1_valid;
  dec_class_e    cls;
  logic          dec_bit;

  bundle_popcount #(.N(N)) u_popcount (
    .bits  (bundle_i),
    .count (pop_now)
  );

  // Gate data with valid so idle-cycle garbage never reaches the statistics path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_pop   <= '0;
      s1_exp   <= 1'b0;
    end else begin
      s1_valid <= bundle_valid_i;
      s1_pop   <= bundle_valid_i ? pop_now : '0;
      s1_exp   <= bundle_valid_i & expected_i;
    end
  end

  always_comb begin
    cls     = DEC_AMBIG;
    dec_bit = 1'b0;
    if (s1_pop >= HI_P) begin
      cls     = DEC_ONE;
      dec_bit = 1'b1;
    end else if (s1_pop <= LO_P) begin
      cls     = DEC_ZERO;
      dec_bit = 1'b0;
    end else begin
      // Inside the band fall back to strict majority; a tie reads as 0.
      cls     = DEC_AMBIG;
      dec_bit = ({s1_pop, 1'b0} > N_P);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_o     <= 1'b0;
      bit_o       <= 1'b0;
      ambiguous_o <= 1'b0;
      popcount_o  <= '0;
    end else begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        bit_o       <= dec_bit;
        ambiguous_o <= (cls == DEC_AMBIG);
        popcount_o  <= s1_pop;
      end
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] value);
    return CNT_W'(sat_inc(SAT_MAX_W'(value), CNT_W));
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      samples_o   <= '0;
      errors_o    <= '0;
      ambig_cnt_o <= '0;
    end else if (s1_valid) begin
      samples_o <= bump(samples_o);
      if (dec_bit != s1_exp) begin
        errors_o <= bump(errors_o);
      end
      if (cls == DEC_AMBIG) begin
        ambig_cnt_o <= bump(ambig_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_bundle_decoder.sv
// Randomized and directed checks of bundle_decoder against a cycle-level reference model,
// with a second narrow-counter instance exercising saturation.
module tb_bundle_decoder;

  localparam int N     = 10;
  localparam int HI    = 7;
  localparam int LO    = 3;
  localparam int PW    = 4;
  localparam int SMALL = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  bundle;
  logic          bundle_valid;
  logic          expected;
  logic          clear;

  logic          bit_o, ambiguous_o, valid_o;
  logic [PW-1:0] popcount_o;
  logic [31:0]   samples_o, errors_o, ambig_cnt_o;

  logic          sm_bit, sm_amb, sm_valid;
  logic [PW-1:0] sm_pop;
  logic [SMALL-1:0] sm_samples, sm_errors, sm_ambig;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bundle_decoder #(.N(N), .THRESH_HI(HI), .THRESH_LO(LO), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .bundle_valid_i(bundle_valid),
    .expected_i(expected), .clear_i(clear), .bit_o(bit_o), .ambiguous_o(ambiguous_o),
    .popcount_o(popcount_o), .valid_o(valid_o), .samples_o(samples_o),
    .errors_o(errors_o), .ambig_cnt_o(ambig_cnt_o)
  );

  bundle_decoder #(.N(N), .THRESH_HI(HI), .THRESH_LO(LO), .CNT_W(SMALL)) dut_small (
    .clk(clk), .reset_n(reset_n), .bundle_i(bundle), .bundle_valid_i(bundle_valid),
    .expected_i(expected), .clear_i(clear), .bit_o(sm_bit), .ambiguous_o(sm_amb),
    .popcount_o(sm_pop), .valid_o(sm_valid), .samples_o(sm_samples),
    .errors_o(sm_errors), .ambig_cnt_o(sm_ambig)
  );

  // Reference model: one in-flight slot plus the visible output state.
  int  m_s1_valid, m_s1_pop, m_s1_exp;
  int  m_valid, m_bit, m_amb, m_pop;
  longint m_samples, m_errors, m_ambig;
  longint s_samples, s_errors, s_ambig;

  function automatic longint sat_add(input longint cur, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (cur >= lim) ? lim : cur + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int p, b, a;
    if (!reset_n) begin
      m_s1_valid = 0; m_s1_pop = 0; m_s1_exp = 0;
      m_valid = 0; m_bit = 0; m_amb = 0; m_pop = 0;
      m_samples = 0; m_errors = 0; m_ambig = 0;
      s_samples = 0; s_errors = 0; s_ambig = 0;
      return;
    end
    if (m_s1_valid != 0) begin
      p = m_s1_pop;
      if (p >= HI) begin b = 1; a = 0; end
      else if (p <= LO) begin b = 0; a = 0; end
      else begin a = 1; b = (2 * p > N) ? 1 : 0; end
      m_valid = 1; m_bit = b; m_amb = a; m_pop = p;
      if (!clear) begin
        m_samples = sat_add(m_samples, 32); s_samples = sat_add(s_samples, SMALL);
        if (b != m_s1_exp) begin
          m_errors = sat_add(m_errors, 32); s_errors = sat_add(s_errors, SMALL);
        end
        if (a != 0) begin
          m_ambig = sat_add(m_ambig, 32); s_ambig = sat_add(s_ambig, SMALL);
        end
      end
    end else begin
      m_valid = 0;
    end
    if (clear) begin
      m_samples = 0; m_errors = 0; m_ambig = 0;
      s_samples = 0; s_errors = 0; s_ambig = 0;
    end
    m_s1_valid = bundle_valid ? 1 : 0;
    m_s1_pop   = bundle_valid ? $countones(bundle) : 0;
    m_s1_exp   = (bundle_valid && expected) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("valid",      64'(valid_o),     64'(m_valid));
    check("bit",        64'(bit_o),       64'(m_bit));
    check("ambiguous",  64'(ambiguous_o), 64'(m_amb));
    check("popcount",   64'(popcount_o),  64'(m_pop));
    check("samples",    64'(samples_o),   64'(m_samples));
    check("errors",     64'(errors_o),    64'(m_errors));
    check("ambig_cnt",  64'(ambig_cnt_o), 64'(m_ambig));
    check("sm_valid",   64'(sm_valid),    64'(m_valid));
    check("sm_bit",     64'(sm_bit),      64'(m_bit));
    check("sm_samples", 64'(sm_samples),  64'(s_samples));
    check("sm_errors",  64'(sm_errors),   64'(s_errors));
    check("sm_ambig",   64'(sm_ambig),    64'(s_ambig));
  endtask

  // Apply inputs for one clock edge, advance the model, then check just after the edge.
  task automatic cycle(input logic rst_n, input logic v, input logic [N-1:0] b,
                       input logic e, input logic c);
    reset_n      = rst_n;
    bundle_valid = v;
    bundle       = b;
    expected     = e;
    clear        = c;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, N'($urandom), 1'($urandom), 1'b0);
  endtask

  function automatic logic [N-1:0] bundle_with(input int p);
    logic [N-1:0] v;
    v = '0;
    while ($countones(v) < p) v[$urandom_range(N - 1, 0)] = 1'b1;
    return v;
  endfunction

  initial begin
    reset_n = 1'b0; bundle_valid = 1'b0; bundle = '0; expected = 1'b0; clear = 1'b0;
    m_s1_valid = 0; m_s1_pop = 0; m_s1_exp = 0;
    m_valid = 0; m_bit = 0; m_amb = 0; m_pop = 0;
    m_samples = 0; m_errors = 0; m_ambig = 0;
    s_samples = 0; s_errors = 0; s_ambig = 0;
    #2;

    // Reset state.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_samples", 64'(samples_o), 64'd0);

    // All-ones bundle: solid 1 two cycles later.
    cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0);
    check("lat1_valid", 64'(valid_o), 64'd0);
    idle(1);
    check("full_valid", 64'(valid_o), 64'd1);
    check("full_pop", 64'(popcount_o), 64'd10);
    check("full_samples", 64'(samples_o), 64'd1);

    // Lower threshold edge counts an error; tie inside the band decodes 0.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 10'h007, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 10'h01F, 1'b0, 1'b0);
    check("lo_bit", 64'(bit_o), 64'd0);
    check("lo_errors", 64'(errors_o), 64'd1);
    idle(1);
    check("tie_amb", 64'(ambiguous_o), 64'd1);
    check("tie_bit", 64'(bit_o), 64'd0);
    check("tie_ambcnt", 64'(ambig_cnt_o), 64'd1);
    check("tie_errors", 64'(errors_o), 64'd1);

    // Back-to-back p = 0, 7, 6, 10.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 10'h07F, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 10'h03F, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0);
    idle(1);
    check("b2b_samples", 64'(samples_o), 64'd4);
    check("b2b_ambcnt", 64'(ambig_cnt_o), 64'd1);
    check("b2b_errors", 64'(errors_o), 64'd0);

    // Clear coincides with stage-2 load.
    cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b1);
    idle(0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("clr_valid", 64'(valid_o), 64'd1);
    check("clr_bit", 64'(bit_o), 64'd1);
    check("clr_samples", 64'(samples_o), 64'd0);
    cycle(1'b1, 1'b1, 10'h000, 1'b0, 1'b0);
    idle(1);
    check("clr_next", 64'(samples_o), 64'd1);

    // Saturation of the 3-bit instance.
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 10'h000, 1'b1, 1'b0);
    idle(2);
    check("sat_samples", 64'(sm_samples), 64'd7);
    check("sat_errors", 64'(sm_errors), 64'd7);
    check("wide_samples", 64'(samples_o), 64'd9);

    // Reset with two bundles in flight.
    cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 10'h3FF, 1'b1, 1'b0);
    check("flush_valid", 64'(valid_o), 64'd0);
    check("flush_pop", 64'(popcount_o), 64'd0);
    idle(1);
    check("flush_valid2", 64'(valid_o), 64'd0);
    cycle(1'b1, 1'b1, 10'h0FF, 1'b1, 1'b0);
    check("post_lat1", 64'(valid_o), 64'd0);
    idle(1);
    check("post_lat2", 64'(valid_o), 64'd1);
    check("post_pop", 64'(popcount_o), 64'd8);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 1500; i++) begin
      logic v, c, r, e;
      logic [N-1:0] b;
      r = ($urandom_range(99, 0) != 0);
      v = ($urandom_range(9, 0) < 7);
      c = ($urandom_range(29, 0) == 0);
      e = 1'($urandom);
      b = ($urandom_range(1, 0) == 0) ? N'($urandom) : bundle_with($urandom_range(N, 0));
      cycle(r, v, b, e, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bundle_decoder.md
Name: bundle_decoder

Overview:
- Downstream stage of the reliable NAND wrapper; consumes its registered N-wire output bundle and valid.
- Decides the logical bit by thresholded popcount (von Neumann restoring-bundle interpretation) and flags bundles inside the ambiguous band.
- Compares each decision against a golden expected bit and accumulates saturating sample, error and ambiguity statistics for simulation sweeps over ERROR_PROBABILITY.

Parameters:
- N, 10, bundle width in wires; must match the upstream stage.
- THRESH_HI, 7, popcount >= THRESH_HI decodes as logic 1.
- THRESH_LO, 3, popcount <= THRESH_LO decodes as logic 0.
- CNT_W, 32, width of each statistics counter.
- Legal range: 0 <= THRESH_LO < THRESH_HI <= N. Elaboration fails with $error outside this range.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- bundle_i  in  N  wire bundle from the upstream stage
- bundle_valid_i  in  1  bundle_i is valid this cycle
- expected_i  in  1  golden logical value for bundle_i; sampled with bundle_valid_i
- clear_i  in  1  synchronous clear of the statistics counters
- bit_o  out  1  decoded logical bit
- ambiguous_o  out  1  popcount fell strictly between THRESH_LO and THRESH_HI
- popcount_o  out  PW  popcount of the decoded bundle; PW = $clog2(N+1)
- valid_o  out  1  bit_o, ambiguous_o and popcount_o are valid
- samples_o  out  CNT_W  number of decoded bundles
- errors_o  out  CNT_W  number of decodes with bit_o != expected
- ambig_cnt_o  out  CNT_W  number of ambiguous decodes

Behaviour:
- Reset is synchronous (reset_n low at a clk edge). It drives every output and every pipeline register to 0, including all valid bits and all counters.
- Pipeline: two stages, no backpressure. Every cycle accepts a new bundle.
- Stage 1 registers popcount(bundle_i), expected_i and bundle_valid_i.
- Stage 2 registers the classification and raises valid_o.
- Latency is exactly 2 cycles from bundle_valid_i to valid_o. Throughput is 1 bundle/cycle. Back-to-back inputs give back-to-back outputs.
- Classification at stage 2, on popcount p:
  - p >= THRESH_HI: class ONE, bit_o=1, ambiguous_o=0.
  - p <= THRESH_LO: class ZERO, bit_o=0, ambiguous_o=0.
  - Otherwise: class AMBIG, ambiguous_o=1, bit_o = (2*p > N), i.e. strict majority; a tie gives 0.
- bit_o, ambiguous_o and popcount_o hold their last value while valid_o=0. They are meaningful only when valid_o=1.
- Counters update in the cycle the stage-2 register loads, so the new counts are visible together with valid_o:
  - samples +1.
  - errors +1 if the decoded bit != the pipelined expected bit.
  - ambig_cnt +1 if AMBIG. An AMBIG sample can also count as an error.
- Counters saturate at all-ones and never wrap.
- clear_i has priority over increments. If clear_i coincides with a stage-2 load, the counters go to 0 and that sample is not counted. The decoded outputs and valid_o of that sample are still produced normally.
- clear_i does not affect the pipeline.
- Reset mid-operation flushes both stages. No output valid_o appears for bundles accepted before reset. The first bundle accepted after reset deasserts emerges 2 cycles later.
- bundle_i and expected_i are don't-care when bundle_valid_i=0. X on them must not propagate into the counters.

Decomposition:
- Package bundle_decoder_pkg holds:
  - typedef enum logic [1:0] {DEC_ZERO, DEC_ONE, DEC_AMBIG} dec_class_e.
  - Function popcount_width(n) returning $clog2(n+1).
  - Function sat_inc for the saturating counter increment.
- Sub-module bundle_popcount (parameter N; combinational adder tree, output width PW) is instantiated in stage 1 and reusable by other restoring-organ blocks.

Test Plan (N=10, THRESH_LO=3, THRESH_HI=7, CNT_W=32 unless stated):
- bundle_i=10'h3FF, expected_i=1, one valid pulse at cycle t -> at t+2: valid_o=1, bit_o=1, ambiguous_o=0, popcount_o=10, samples_o=1, errors_o=0.
- bundle_i=10'h007 (p=3), expected_i=1 -> bit_o=0, ambiguous_o=0, errors_o=1. Then 10'h01F (p=5), expected_i=0 -> ambiguous_o=1, bit_o=0 (tie), ambig_cnt_o=1, errors_o unchanged at 1.
- Four consecutive valid cycles with p=0, 7, 6, 10 and expected 0,1,1,1 -> four consecutive valid_o cycles with bit_o 0,1,1,1 and ambiguous_o 0,0,1,0; samples_o=4, ambig_cnt_o=1, errors_o=0.
- clear_i asserted in the same cycle a sample reaches stage 2 -> that sample's valid_o=1 with correct bit_o; all counters read 0 the next cycle. The following sample gives samples_o=1.
- CNT_W=3, 9 bundles with p=0 and expected 1 -> samples_o=7 and errors_o=7, held saturated, no wrap.
- Two bundles in flight, reset_n low for one cycle -> no valid_o for either bundle, all outputs 0. A new bundle after reset gives valid_o exactly 2 cycles later.
